// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch/decode sequencer with return stack
module fetch_sequencer #(
    parameter int STACK_DEPTH = 4,
    parameter int PC_WIDTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [PC_WIDTH-1:0] rom_addr,
    input  logic [7:0]          rom_data,
    output logic [7:0]          instr_out,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic                halted,
    output logic                fault,
    output logic [1:0]          fault_code,
    output logic [2:0]          stack_depth
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [2:0] LP_FULL     = 3'(STACK_DEPTH);
    localparam logic [1:0] LP_FC_OVER  = 2'b01;
    localparam logic [1:0] LP_FC_UNDER = 2'b10;

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [7:0]          r_ir;
    logic [2:0]          r_depth;
    logic [1:0]          r_fault_code;
    // Sized to the full 3-bit depth range so the depth counter indexes it directly.
    logic [PC_WIDTH-1:0] r_stack [0:7];

    logic                w_is_nop;
    logic                w_is_br;
    logic                w_is_ret;
    logic                w_is_hlt;
    logic                w_full;
    logic                w_empty;
    logic                w_restart;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_br_target;
    logic [2:0]          w_top_idx;

    assign w_is_nop    = (r_ir == 8'h00);
    assign w_is_br     = (r_ir[7:4] == 4'b1100);
    assign w_is_ret    = (r_ir == 8'hB0);
    assign w_is_hlt    = (r_ir == 8'hFF);
    assign w_full      = (r_depth == LP_FULL);
    assign w_empty     = (r_depth == 3'd0);
    assign w_pc_inc    = r_pc + PC_WIDTH'(1);
    assign w_br_target = PC_WIDTH'(r_ir[3:0]);
    assign w_top_idx   = r_depth - 3'd1;
    assign w_restart   = start && ((r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_FAULT));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT, S_FAULT: begin
                if (start) w_next = S_FETCH;
            end
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_nop)      w_next = S_FETCH;
                else if (w_is_br)  w_next = w_full  ? S_FAULT : S_FETCH;
                else if (w_is_ret) w_next = w_empty ? S_FAULT : S_FETCH;
                else if (w_is_hlt) w_next = S_HALT;
                else               w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (instr_ready) w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Program counter, instruction register, stack pointer and fault cause
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= '0;
            r_ir         <= '0;
            r_depth      <= '0;
            r_fault_code <= '0;
        end else if (w_restart) begin
            r_pc         <= '0;
            r_depth      <= '0;
            r_fault_code <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_ir <= rom_data;
                S_DECODE: begin
                    if (w_is_nop) begin
                        r_pc <= w_pc_inc;
                    end else if (w_is_br) begin
                        if (w_full) begin
                            r_fault_code <= LP_FC_OVER;
                        end else begin
                            r_pc    <= w_br_target;
                            r_depth <= r_depth + 3'd1;
                        end
                    end else if (w_is_ret) begin
                        if (w_empty) begin
                            r_fault_code <= LP_FC_UNDER;
                        end else begin
                            r_pc    <= r_stack[w_top_idx];
                            r_depth <= w_top_idx;
                        end
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) r_pc <= w_pc_inc;
                end
                default: ;
            endcase
        end
    end

    // Return-address storage; contents are only meaningful below r_depth
    always_ff @(posedge clk) begin
        if ((r_state == S_DECODE) && w_is_br && !w_full) begin
            r_stack[r_depth] <= w_pc_inc;
        end
    end

    // Outputs decode straight from state so reset drops them immediately
    always_comb begin
        rom_addr    = r_pc;
        instr_valid = (r_state == S_ISSUE);
        instr_out   = (r_state == S_ISSUE) ? r_ir : 8'h00;
        halted      = (r_state == S_HALT);
        fault       = (r_state == S_FAULT);
        fault_code  = r_fault_code;
        stack_depth = r_depth;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic       instr_ready;
    logic       halted;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] stack_depth;

    logic [7:0] rom [0:15];
    logic [7:0] q [$];
    int         maxd;
    int         checks = 0;
    int         errors = 0;
    int         bad;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    fetch_sequencer #(.STACK_DEPTH(4), .PC_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .halted(halted), .fault(fault), .fault_code(fault_code), .stack_depth(stack_depth)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rom_fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    task automatic run_collect(input int budget);
        q.delete();
        maxd = 0;
        for (int n = 0; n < budget && !halted && !fault; n++) begin
            if (instr_valid && instr_ready) q.push_back(instr_out);
            if (int'(stack_depth) > maxd) maxd = int'(stack_depth);
            tick();
        end
    endtask

    task automatic load_main();
        rom_fill(8'h00);
        rom[4]  = 8'h91; rom[5]  = 8'hCA; rom[6]  = 8'h61; rom[7] = 8'h97;
        rom[8]  = 8'hFF; rom[10] = 8'h12; rom[11] = 8'h13; rom[12] = 8'hB0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_main [0:4];
        exp_main[0] = 8'h91; exp_main[1] = 8'h12; exp_main[2] = 8'h13;
        exp_main[3] = 8'h61; exp_main[4] = 8'h97;
        rst = 1'b1; start = 1'b0; instr_ready = 1'b1;
        rom_fill(8'h00);

        // Reset state
        #2;
        chk("rst_valid", instr_valid, 0);
        chk("rst_out",   instr_out, 0);
        chk("rst_pc",    rom_addr, 0);
        chk("rst_halt",  halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fc",    fault_code, 0);
        chk("rst_depth", stack_depth, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_stays", rom_addr, 0);

        // Main program, always ready
        load_main();
        do_start();
        run_collect(300);
        chk("main_halted", halted, 1);
        chk("main_count", q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("main_issue%0d", i), (q.size() > i) ? q[i] : 8'hxx, exp_main[i]);
        chk("main_pc", rom_addr, 8);
        chk("main_maxd", maxd, 1);
        tick(); tick();
        chk("halt_hold_pc", rom_addr, 8);
        chk("halt_hold", halted, 1);

        // Back-pressure on first issue
        do_reset();
        instr_ready = 1'b0;
        do_start();
        for (int n = 0; n < 50 && !instr_valid; n++) tick();
        chk("bp_valid_seen", instr_valid, 1);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (instr_valid !== 1'b1 || instr_out !== 8'h91 || rom_addr !== 4'd4) bad++;
            tick();
        end
        instr_ready = 1'b1;
        if (instr_valid !== 1'b1 || instr_out !== 8'h91 || rom_addr !== 4'd4) bad++;
        chk("bp_stable_6cyc", bad, 0);
        tick();
        chk("bp_accept_valid", instr_valid, 0);
        chk("bp_accept_pc", rom_addr, 5);
        run_collect(300);
        chk("bp_halted", halted, 1);

        // Return-stack underflow
        do_reset();
        rom_fill(8'h00);
        rom[0] = 8'hB0;
        do_start();
        for (int n = 0; n < 20 && !fault; n++) tick();
        chk("uf_fault", fault, 1);
        chk("uf_code", fault_code, 2'b10);
        chk("uf_pc", rom_addr, 0);
        chk("uf_depth", stack_depth, 0);
        do_start();
        chk("uf_restart_fc", fault_code, 0);
        chk("uf_restart_fault", fault, 0);

        // Return-stack overflow from a self-branch
        do_reset();
        rom_fill(8'h00);
        rom[0] = 8'hC0;
        do_start();
        for (int n = 0; n < 40 && !fault; n++) tick();
        chk("of_fault", fault, 1);
        chk("of_code", fault_code, 2'b01);
        chk("of_depth", stack_depth, 4);
        chk("of_pc", rom_addr, 0);

        // LIFO ordering with nested calls
        do_reset();
        rom_fill(8'h00);
        rom[0] = 8'hC4; rom[1] = 8'h21; rom[2] = 8'hFF;
        rom[4] = 8'hC8; rom[5] = 8'h55; rom[6] = 8'hB0; rom[8] = 8'hB0;
        do_start();
        run_collect(200);
        chk("lifo_halted", halted, 1);
        chk("lifo_count", q.size(), 2);
        chk("lifo_first", (q.size() > 0) ? q[0] : 8'hxx, 8'h55);
        chk("lifo_second", (q.size() > 1) ? q[1] : 8'hxx, 8'h21);
        chk("lifo_maxd", maxd, 2);
        chk("lifo_pc", rom_addr, 2);

        // All-NOP sweep with PC wrap, then restart from HALT
        do_reset();
        rom_fill(8'h00);
        do_start();
        bad = 0;
        for (int i = 0; i < 34; i++) begin
            if (rom_addr !== 4'((i / 2) % 16) || instr_valid !== 1'b0) bad++;
            tick();
        end
        chk("nop_sweep_wrap", bad, 0);
        rom[5] = 8'hFF;
        for (int n = 0; n < 40 && !halted; n++) tick();
        chk("nop_halted", halted, 1);
        chk("nop_halt_pc", rom_addr, 5);
        do_start();
        chk("nop_restart_pc", rom_addr, 0);
        chk("nop_restart_halt", halted, 0);
        tick(); tick();
        chk("nop_resume_pc", rom_addr, 1);

        // Asynchronous reset during ISSUE
        do_reset();
        rom_fill(8'h00);
        rom[0] = 8'h91;
        instr_ready = 1'b0;
        do_start();
        for (int n = 0; n < 20 && !instr_valid; n++) tick();
        chk("ar_valid_before", instr_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid_async", instr_valid, 0);
        chk("ar_out_async", instr_out, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("ar_idle_valid", instr_valid, 0);
        chk("ar_idle_pc", rom_addr, 0);
        do_start();
        for (int n = 0; n < 20 && !instr_valid; n++) tick();
        chk("ar_resume_out", instr_out, 8'h91);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
